// File: rtl/myPkg.sv
// Shared display helpers for the seven-segment path.
//
// seg_drv: hex nibble to segment pattern. Bit map is {dp, g, f, e, d, c, b, a},
// active-high; the decimal point is never lit.
package myPkg;

    function automatic logic [7:0] seg_drv(input logic [3:0] val);
        logic [7:0] pat;
        pat = 8'h00;
        case (val)
            4'h0: pat = 8'h3f;
            4'h1: pat = 8'h06;
            4'h2: pat = 8'h5b;
            4'h3: pat = 8'h4f;
            4'h4: pat = 8'h66;
            4'h5: pat = 8'h6d;
            4'h6: pat = 8'h7d;
            4'h7: pat = 8'h07;
            4'h8: pat = 8'h7f;
            4'h9: pat = 8'h6f;
            4'ha: pat = 8'h77;
            4'hb: pat = 8'h7c;
            4'hc: pat = 8'h39;
            4'hd: pat = 8'h5e;
            4'he: pat = 8'h79;
            default: pat = 8'h71;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller.
//
// Holds one 4-bit value per digit and cycles a shared segment bus across
// NUM_DIG one-hot digit enables. Each digit slot is BLANK_CYC all-off cycles
// followed by HOLD_CYC driven cycles. frame_tick pulses in the first blank
// cycle after the last digit of a frame.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   en         in   scan enable (level)
//   wr_en      in   digit register write strobe
//   wr_idx     in   digit index to write (out-of-range writes are dropped)
//   wr_data    in   4-bit value to store
//   seg        out  segment pattern from myPkg::seg_drv, zero when not driving
//   dig_sel    out  one-hot digit enable, zero when not driving
//   frame_tick out  one-cycle end-of-frame pulse
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIG   = 3,
    parameter int unsigned HOLD_CYC  = 1000,
    parameter int unsigned BLANK_CYC = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       wr_en,
    input  logic [$clog2(NUM_DIG)-1:0] wr_idx,
    input  logic [3:0]                 wr_data,
    output logic [7:0]                 seg,
    output logic [NUM_DIG-1:0]         dig_sel,
    output logic                       frame_tick
);

    localparam int unsigned IdxW   = $clog2(NUM_DIG);
    localparam int unsigned MaxCyc = (HOLD_CYC > BLANK_CYC) ? HOLD_CYC : BLANK_CYC;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    localparam logic [CntW-1:0] HoldLast  = CntW'(HOLD_CYC - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);
    localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIG - 1);

    typedef enum logic [1:0] {StOff, StBlank, StDrive} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [3:0]          digit_q [NUM_DIG];
    logic [7:0]          seg_q, seg_d;
    logic [NUM_DIG-1:0]  dig_sel_q, dig_sel_d;
    logic                tick_q, tick_d;

    // Next-state logic; en low forces OFF from any state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        tick_d  = 1'b0;
        if (!en) begin
            state_d = StOff;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                StOff: begin
                    state_d = StBlank;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                StBlank: begin
                    if (cnt_q == BlankLast) begin
                        state_d = StDrive;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StDrive: begin
                    if (cnt_q == HoldLast) begin
                        state_d = StBlank;
                        cnt_d   = '0;
                        if (idx_q == IdxLast) begin
                            idx_d  = '0;
                            tick_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StOff;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from next-state values so they move with the state.
    // Segment data comes from the registered digit file, so a write lands one
    // edge after it is captured.
    always_comb begin
        seg_d     = 8'h00;
        dig_sel_d = '0;
        if (state_d == StDrive) begin
            seg_d            = myPkg::seg_drv(digit_q[idx_d]);
            dig_sel_d[idx_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StOff;
            cnt_q     <= '0;
            idx_q     <= '0;
            seg_q     <= 8'h00;
            dig_sel_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            dig_sel_q <= dig_sel_d;
            tick_q    <= tick_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_DIG; i++) begin
                digit_q[i] <= 4'h0;
            end
        end else if (wr_en && (32'(wr_idx) < NUM_DIG)) begin
            digit_q[wr_idx] <= wr_data;
        end
    end

    assign seg        = seg_q;
    assign dig_sel    = dig_sel_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIG=3, HOLD_CYC=8, BLANK_CYC=2.
// Inputs change and outputs are sampled on the falling edge.
module tb_seg_scan_ctrl;

    localparam int Slot = 10;   // BLANK_CYC + HOLD_CYC
    localparam int Frame = 30;  // NUM_DIG * Slot
    localparam int None = -10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       wr_en;
    logic [1:0] wr_idx;
    logic [3:0] wr_data;
    logic [7:0] seg;
    logic [2:0] dig_sel;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_dig [3];

    seg_scan_ctrl #(
        .NUM_DIG  (3),
        .HOLD_CYC (8),
        .BLANK_CYC(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .seg       (seg),
        .dig_sel   (dig_sel),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Hand-written segment table, {dp,g,f,e,d,c,b,a}.
    function automatic logic [7:0] seg_ref(input logic [3:0] v);
        logic [7:0] t [16];
        t = '{8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66, 8'h6d, 8'h7d, 8'h07,
              8'h7f, 8'h6f, 8'h77, 8'h7c, 8'h39, 8'h5e, 8'h79, 8'h71};
        return t[v];
    endfunction

    task automatic chk(input string tag, input int p, input logic [11:0] exp);
        logic [11:0] obs;
        obs = {seg, dig_sel, frame_tick};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s p=%0d got seg=%h sel=%b tick=%b expected seg=%h sel=%b tick=%b",
                   tag, p, obs[11:4], obs[3:1], obs[0], exp[11:4], exp[3:1], exp[0]);
        end
    endtask

    // One scan frame from its first blank cycle. Optional one-cycle write
    // after position wr_at, enable drop after drop_at, reset pulse after rst_at.
    task automatic run_frame(input string tag, input bit tick0, input int wr_at,
                             input logic [1:0] wi, input logic [3:0] wv,
                             input int drop_at, input int rst_at);
        for (int p = 0; p < Frame; p++) begin
            logic [11:0] e;
            int s;
            @(negedge clk);
            if (p == drop_at + 1 || p == rst_at + 1) begin
                chk({tag, "_off"}, p, 12'h000);
                if (p == rst_at + 1) begin
                    rst_n = 1'b1;
                    exp_dig = '{4'h0, 4'h0, 4'h0};
                end
                return;
            end
            s = p / Slot;
            if (p % Slot < 2) begin
                e = {8'h00, 3'b000, (p == 0) ? tick0 : 1'b0};
            end else begin
                e = {seg_ref(exp_dig[s]), 3'(3'b001 << s), 1'b0};
            end
            chk(tag, p, e);
            if (p == wr_at + 1) begin
                wr_en = 1'b0;
                if (wi < 2'd3) exp_dig[wi] = wv;
            end
            if (p == wr_at) begin
                wr_en   = 1'b1;
                wr_idx  = wi;
                wr_data = wv;
            end
            if (p == drop_at) en = 1'b0;
            if (p == rst_at) rst_n = 1'b0;
        end
    endtask

    initial begin
        exp_dig = '{4'h0, 4'h0, 4'h0};
        rst_n   = 1'b0;
        en      = 1'b1;
        wr_en   = 1'b1;
        wr_idx  = 2'd0;
        wr_data = 4'h5;

        // Reset beats en and wr_en.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset", i, 12'h000);
        end
        rst_n = 1'b1;
        wr_en = 1'b0;

        // First frame after reset shows all digits still zero, no tick.
        run_frame("rst_dig", 1'b0, None, 2'd0, 4'h0, None, None);

        // Dropping en on the last drive cycle suppresses the frame tick.
        en = 1'b0;
        @(negedge clk);
        chk("drop_tick", 0, 12'h000);

        // Writes while OFF.
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_idx  = 2'(i);
            wr_data = 4'(i + 1);
            exp_dig[i] = 4'(i + 1);
            @(negedge clk);
            chk("off_wr", i, 12'h000);
        end
        wr_en = 1'b0;
        en    = 1'b1;

        run_frame("nom1", 1'b0, None, 2'd0, 4'h0, None, None);
        run_frame("nom2", 1'b1, None, 2'd0, 4'h0, None, None);
        // Write idx 1 during its 3rd drive cycle.
        run_frame("live", 1'b1, 14, 2'd1, 4'ha, None, None);
        run_frame("illegal", 1'b1, 5, 2'd3, 4'hf, None, None);
        // Drop en in the 5th drive cycle of idx 2.
        run_frame("drop", 1'b1, None, 2'd0, 4'h0, 26, None);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("drop_hold", i, 12'h000);
        end
        en = 1'b1;
        run_frame("reen", 1'b0, None, 2'd0, 4'h0, None, None);
        // Reset pulse during drive of idx 1, en held high.
        run_frame("rst_mid", 1'b1, None, 2'd0, 4'h0, None, 15);
        run_frame("post_rst", 1'b0, None, 2'd0, 4'h0, None, None);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
